gpu_pixel_arbiter: RTL and testbench
====================================

// Module: gpu_pixel_arbiter
// PURPOSE
//  Shares the single frame-buffer pixel write port between the four rasterizers (line, fill, circle, arc).
//  Grants one rasterizer at a time, round-robin, and locks the grant for a whole primitive (until its last pixel).
//  Drives a registered valid/ready pixel stream to the frame-buffer writer.
//  Sequences frame flushes so that a flush is acknowledged only once every in-flight pixel has drained.
// PARAMETERS
//  N_REQ       4   number of requesters; index 0=line, 1=fill, 2=circle, 3=arc
//  COUNT_BITS 20   width of the accepted-pixel counter
// PORTS
//  clk            in   1                     system clock, rising edge
//  rst            in   1                     synchronous, active-high reset
//  req_valid_i    in   N_REQ                 per-requester pixel valid
//  req_last_i     in   N_REQ                 pixel is the last of its primitive
//  req_x_i        in   N_REQ*`WIDTH_BITS     packed x coordinates; slice i belongs to requester i
//  req_y_i        in   N_REQ*`HEIGHT_BITS    packed y coordinates
//  req_rgb_i      in   N_REQ*3*`CHANNEL_BITS packed {r,g,b} colours
//  req_ready_o    out  N_REQ                 pixel accepted from requester i this cycle
//  pix_valid_o    out  1                     output pixel valid
//  pix_x_o        out  `WIDTH_BITS           output x
//  pix_y_o        out  `HEIGHT_BITS          output y
//  pix_r_o/g_o/b_o out `CHANNEL_BITS each    output colour
//  pix_ready_i    in   1                     frame-buffer writer accepts the output pixel
//  flush_frame_i  in   1                     one-cycle flush request from gpu_controller
//  flush_done_o   out  1                     one-cycle pulse when the flush is complete
//  busy_o         out  1                     high when state != IDLE or pix_valid_o is high
//  clipped_o      out  1                     one-cycle pulse per dropped pixel (PIXEL_CLIP_EN only)
//  pix_count_o    out  COUNT_BITS            number of output pixels accepted since the last flush
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, last_grant=N_REQ-1, flush_pend=0; every output is 0.
//  FSM states: IDLE, LOCKED, FLUSH_WAIT.
//  IDLE:
//   - If flush_pend or flush_frame_i is set, go to FLUSH_WAIT. Flush has priority over new grants.
//   - Otherwise, if any req_valid_i is set, pick the first valid requester searching from (last_grant+1) mod N_REQ.
//     Then set grant and last_grant to it and go to LOCKED. The cycle spent in IDLE is a bubble.
//  LOCKED:
//   - req_ready_o[grant] = req_valid_i[grant] && (!pix_valid_o || pix_ready_i). All other ready bits are 0.
//   - An accepted pixel is loaded into the output register and appears on pix_* one cycle after acceptance.
//   - Accepting a pixel with req_last_i[grant] set returns the FSM to IDLE.
//   - A requester that drops valid mid-primitive keeps the grant; there is no timeout.
//  Output register:
//   - pix_valid_o and the data stay stable until pix_ready_i is seen. Data changes only on a load.
//   - Full throughput: one pixel per cycle while pix_ready_i=1.
//   - Simultaneous load and accept: the new pixel replaces the old one and pix_valid_o stays 1.
//  Flush:
//   - flush_frame_i in LOCKED sets flush_pend. The current primitive finishes first and no new grant is issued.
//   - FLUSH_WAIT: once pix_valid_o=0, pulse flush_done_o for one cycle, clear pix_count_o and flush_pend, go to IDLE.
//   - flush_frame_i while already in FLUSH_WAIT is absorbed into the same flush.
//  pix_count_o: +1 on each pix_valid_o && pix_ready_i; wraps modulo 2^COUNT_BITS; cleared by the flush_done_o cycle.
//  Reset asserted mid-primitive or mid-flush: all state returns to reset values and pending pixels are discarded.
// CONFIGURATION
//  PIXEL_CLIP_EN defined:
//   - An accepted pixel with x >= `WIDTH or y >= `HEIGHT is consumed (ready still asserts) but not loaded.
//   - clipped_o pulses in the acceptance cycle.
//   - A clipped pixel carrying last still releases the lock. It is not counted in pix_count_o.
//  PIXEL_CLIP_EN undefined: every pixel is passed through unchanged; clipped_o is tied to 0.
// STRUCTURE
//  gpu_pkg: pixel_t struct {x,y,r,g,b} and arb_state_t enum {IDLE,LOCKED,FLUSH_WAIT}.
//  The existing gpu_definitions.vh supplies `WIDTH, `HEIGHT, `WIDTH_BITS, `HEIGHT_BITS and `CHANNEL_BITS.
//  Sub-module gpu_rr_pick: combinational round-robin picker; inputs valid[N_REQ] and last_grant; outputs idx and any.
// TESTING
//  1. Reset, then line sends 3 pixels (last on the 3rd) with pix_ready_i=1:
//     -> outputs at cycles 2,3,4; FSM returns to IDLE; pix_count_o=3.
//  2. All four requesters valid, each with 2-pixel primitives:
//     -> grant order 0,1,2,3, then 0 again; pixels of different primitives are never interleaved.
//  3. pix_ready_i=0 for 5 cycles mid-stream:
//     -> pix_* stays stable, req_ready_o stays 0, and no pixel is lost or duplicated.
//  4. flush_frame_i during fill's 4-pixel primitive, with circle also valid:
//     -> fill completes, circle is not granted, flush_done_o pulses after drain, pix_count_o=0.
//  5. PIXEL_CLIP_EN, pixel at x=`WIDTH carrying last:
//     -> clipped_o=1 and no output pixel; the lock is released.
//     Without the macro, the same pixel is output unchanged.
//  6. rst asserted while pix_valid_o=1 in LOCKED:
//     -> the next cycle has all outputs 0 and the FSM in IDLE.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared pixel/arbiter types for the GPU pixel path, plus the frame geometry
// defaults normally supplied by gpu_definitions.vh.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

package gpu_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOCKED     = 2'd1,
      FLUSH_WAIT = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [`WIDTH_BITS-1:0]   x;
      logic [`HEIGHT_BITS-1:0]  y;
      logic [`CHANNEL_BITS-1:0] r;
      logic [`CHANNEL_BITS-1:0] g;
      logic [`CHANNEL_BITS-1:0] b;
   } pixel_t;

   function automatic logic pix_in_frame(input pixel_t p);
      return (p.x < `WIDTH) && (p.y < `HEIGHT);
   endfunction

endpackage

// File: rtl/gpu_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant.
module gpu_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IW-1:0]    last_grant,
   output logic [IW-1:0]    idx,
   output logic             any
);

   // Walk the distances from far to near so the nearest valid requester wins.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (valid[(int'(last_grant) + k) % N_REQ]) begin
            idx = IW'((int'(last_grant) + k) % N_REQ);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpu_pixel_arbiter.sv
// Round-robin, primitive-locked arbiter onto the frame-buffer pixel port with flush sequencing.
// Optional build macro PIXEL_CLIP_EN drops accepted pixels that fall outside the frame.
module gpu_pixel_arbiter
   import gpu_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int COUNT_BITS = 20
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_REQ-1:0]                 req_valid_i,
   input  logic [N_REQ-1:0]                 req_last_i,
   input  logic [N_REQ*`WIDTH_BITS-1:0]     req_x_i,
   input  logic [N_REQ*`HEIGHT_BITS-1:0]    req_y_i,
   input  logic [N_REQ*3*`CHANNEL_BITS-1:0] req_rgb_i,
   output logic [N_REQ-1:0]                 req_ready_o,
   output logic                             pix_valid_o,
   output logic [`WIDTH_BITS-1:0]           pix_x_o,
   output logic [`HEIGHT_BITS-1:0]          pix_y_o,
   output logic [`CHANNEL_BITS-1:0]         pix_r_o,
   output logic [`CHANNEL_BITS-1:0]         pix_g_o,
   output logic [`CHANNEL_BITS-1:0]         pix_b_o,
   input  logic                             pix_ready_i,
   input  logic                             flush_frame_i,
   output logic                             flush_done_o,
   output logic                             busy_o,
   output logic                             clipped_o,
   output logic [COUNT_BITS-1:0]            pix_count_o
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int XW = `WIDTH_BITS;
   localparam int YW = `HEIGHT_BITS;
   localparam int CW = `CHANNEL_BITS;

   arb_state_t            state;
   logic [IW-1:0]         grant;
   logic [IW-1:0]         last_grant;
   logic                  flush_pend;
   logic                  flush_done;
   logic [COUNT_BITS-1:0] count;
   logic [IW-1:0]         pick_idx;
   logic                  pick_any;

   pixel_t sel_p0;
   logic   sel_last_p0;
   logic   accept_p0;
   logic   clip_p0;
   logic   load_p0;
   pixel_t pix_p1;
   logic   vld_p1;

   gpu_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .valid      (req_valid_i),
      .last_grant (last_grant),
      .idx        (pick_idx),
      .any        (pick_any)
   );

   // Stage p0: select the granted requester and decide acceptance
   always_comb begin
      sel_p0.x    = req_x_i[int'(grant)*XW +: XW];
      sel_p0.y    = req_y_i[int'(grant)*YW +: YW];
      {sel_p0.r, sel_p0.g, sel_p0.b} = req_rgb_i[int'(grant)*3*CW +: 3*CW];
      sel_last_p0 = req_last_i[grant];
      accept_p0   = (state == LOCKED) && req_valid_i[grant] && (!vld_p1 || pix_ready_i);
      req_ready_o = '0;
      req_ready_o[grant] = accept_p0;
   end

`ifdef PIXEL_CLIP_EN
   assign clip_p0 = accept_p0 && !pix_in_frame(sel_p0);
`else
   assign clip_p0 = 1'b0;
`endif

   assign load_p0   = accept_p0 && !clip_p0;
   assign clipped_o = clip_p0;

   // Stage p1: output register, counter and FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= IW'(N_REQ - 1);
         flush_pend <= 1'b0;
         flush_done <= 1'b0;
         count      <= '0;
         vld_p1     <= 1'b0;
         pix_p1     <= '0;
      end else begin
         flush_done <= 1'b0;
         if (load_p0) begin
            vld_p1 <= 1'b1;
            pix_p1 <= sel_p0;
         end else if (pix_ready_i) begin
            vld_p1 <= 1'b0;
         end
         if (vld_p1 && pix_ready_i)
            count <= count + COUNT_BITS'(1);
         case (state)
            IDLE: begin
               if (flush_pend || flush_frame_i) begin
                  state <= FLUSH_WAIT;
               end else if (pick_any) begin
                  grant      <= pick_idx;
                  last_grant <= pick_idx;
                  state      <= LOCKED;
               end
            end
            LOCKED: begin
               if (flush_frame_i)
                  flush_pend <= 1'b1;
               if (accept_p0 && sel_last_p0)
                  state <= IDLE;
            end
            FLUSH_WAIT: begin
               // vld_p1 low means nothing is left in flight to the writer
               if (!vld_p1) begin
                  flush_done <= 1'b1;
                  count      <= '0;
                  flush_pend <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign pix_valid_o  = vld_p1;
   assign pix_x_o      = pix_p1.x;
   assign pix_y_o      = pix_p1.y;
   assign pix_r_o      = pix_p1.r;
   assign pix_g_o      = pix_p1.g;
   assign pix_b_o      = pix_p1.b;
   assign flush_done_o = flush_done;
   assign busy_o       = (state != IDLE) || vld_p1;
   assign pix_count_o  = count;

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
// Randomised bench for gpu_pixel_arbiter against a transaction-level reference model.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module tb_gpu_pixel_arbiter;

   localparam int N  = 4;
   localparam int CB = 20;
   localparam int XW = `WIDTH_BITS;
   localparam int YW = `HEIGHT_BITS;
   localparam int CW = `CHANNEL_BITS;
`ifdef PIXEL_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req_valid_i = '0;
   logic [N-1:0]      req_last_i = '0;
   logic [N*XW-1:0]   req_x_i = '0;
   logic [N*YW-1:0]   req_y_i = '0;
   logic [N*3*CW-1:0] req_rgb_i = '0;
   logic [N-1:0]      req_ready_o;
   logic              pix_valid_o;
   logic [XW-1:0]     pix_x_o;
   logic [YW-1:0]     pix_y_o;
   logic [CW-1:0]     pix_r_o, pix_g_o, pix_b_o;
   logic              pix_ready_i = 1'b0;
   logic              flush_frame_i = 1'b0;
   logic              flush_done_o;
   logic              busy_o;
   logic              clipped_o;
   logic [CB-1:0]     pix_count_o;

   gpu_pixel_arbiter #(.N_REQ(N), .COUNT_BITS(CB)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_last_i(req_last_i),
      .req_x_i(req_x_i), .req_y_i(req_y_i), .req_rgb_i(req_rgb_i),
      .req_ready_o(req_ready_o),
      .pix_valid_o(pix_valid_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
      .pix_r_o(pix_r_o), .pix_g_o(pix_g_o), .pix_b_o(pix_b_o),
      .pix_ready_i(pix_ready_i), .flush_frame_i(flush_frame_i),
      .flush_done_o(flush_done_o), .busy_o(busy_o), .clipped_o(clipped_o),
      .pix_count_o(pix_count_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Requester-side traffic generators
   bit            hold[N];
   bit            gl[N];
   int            left[N];
   int            quota[N];
   logic [XW-1:0] gx[N];
   logic [YW-1:0] gy[N];
   logic [CW-1:0] gr[N], gg[N], gb[N];
   int  len_fix = 0, vpct = 100, rpct = 100, clip_pct = 0;
   bit  flush_req = 0, rst_req = 0;

   // Reference model: owner is the locked requester (-1 when none)
   int            m_owner, m_last, m_acc;
   bit            m_flushing, m_pend, m_ov, m_done, m_clip;
   logic [XW-1:0] m_x;
   logic [YW-1:0] m_y;
   logic [CW-1:0] m_r, m_g, m_b;
   logic [CB-1:0] m_cnt;

   // Observations for the directed scenarios
   int cyc = 0, first_out = -1, last_out = -1, n_out = 0, n_clip = 0;
   int done_cyc = -1, circ_cyc = -1;
   bit done_seen = 0, prev_last = 1;
   int order_q[$];

   task automatic model_reset();
      m_owner = -1; m_last = N - 1; m_flushing = 0; m_pend = 0; m_ov = 0; m_done = 0;
      m_x = '0; m_y = '0; m_r = '0; m_g = '0; m_b = '0; m_cnt = '0;
   endtask

   task automatic gen_drive();
      for (int i = 0; i < N; i++) begin
         if (!hold[i]) begin
            if (left[i] == 0 && quota[i] > 0 && $urandom_range(0, 99) < vpct) begin
               quota[i]--;
               left[i] = (len_fix > 0) ? len_fix : int'($urandom_range(1, 4));
            end
            if (left[i] > 0 && $urandom_range(0, 99) < vpct) begin
               hold[i] = 1;
               gx[i] = ($urandom_range(0, 99) < clip_pct) ? XW'($urandom_range(`WIDTH, (1 << XW) - 1))
                                                         : XW'($urandom_range(0, `WIDTH - 1));
               gy[i] = ($urandom_range(0, 99) < clip_pct) ? YW'($urandom_range(`HEIGHT, (1 << YW) - 1))
                                                         : YW'($urandom_range(0, `HEIGHT - 1));
               gr[i] = CW'($urandom); gg[i] = CW'($urandom); gb[i] = CW'($urandom);
               gl[i] = (left[i] == 1);
            end
         end
         req_valid_i[i] = hold[i];
         req_last_i[i]  = gl[i];
         req_x_i[i*XW +: XW] = gx[i];
         req_y_i[i*YW +: YW] = gy[i];
         req_rgb_i[i*3*CW +: 3*CW] = {gr[i], gg[i], gb[i]};
      end
      pix_ready_i   = ($urandom_range(0, 99) < rpct);
      flush_frame_i = flush_req;
      rst           = rst_req;
      flush_req = 0;
      rst_req   = 0;
   endtask

   task automatic model_next();
      bit ov_old;
      ov_old = m_ov;
      if (rst) begin
         model_reset();
      end else begin
         m_done = 0;
         if (m_ov && pix_ready_i) m_cnt = m_cnt + 1'b1;
         if (m_acc >= 0 && !m_clip) begin
            m_ov = 1; m_x = gx[m_acc]; m_y = gy[m_acc];
            m_r = gr[m_acc]; m_g = gg[m_acc]; m_b = gb[m_acc];
         end else if (pix_ready_i) begin
            m_ov = 0;
         end
         if (m_owner >= 0) begin
            if (flush_frame_i) m_pend = 1;
            if (m_acc >= 0 && gl[m_acc]) m_owner = -1;
         end else if (m_flushing) begin
            if (!ov_old) begin
               m_done = 1; m_cnt = '0; m_pend = 0; m_flushing = 0;
            end
         end else if (m_pend || flush_frame_i) begin
            m_flushing = 1;
         end else begin
            for (int k = 1; k <= N; k++) begin
               if (hold[(m_last + k) % N]) begin
                  m_owner = (m_last + k) % N;
                  m_last  = m_owner;
                  break;
               end
            end
         end
      end
      if (m_acc >= 0) begin
         hold[m_acc] = 0;
         left[m_acc]--;
      end
   endtask

   task automatic step();
      gen_drive();
      #1;
      m_acc = -1;
      if (m_owner >= 0)
         if (hold[m_owner] && (!m_ov || pix_ready_i)) m_acc = m_owner;
      m_clip = CLIP && (m_acc >= 0) && (gx[m_acc] >= `WIDTH || gy[m_acc] >= `HEIGHT);
      chk("req_ready", 32'(req_ready_o), (m_acc >= 0) ? (32'd1 << m_acc) : 32'd0);
      chk("clipped", 32'(clipped_o), 32'(m_clip));
      for (int i = 0; i < N; i++) begin
         if (req_ready_o[i]) begin
            if (prev_last) order_q.push_back(i);
            prev_last = req_last_i[i];
            if (i == 2 && circ_cyc < 0) circ_cyc = cyc;
         end
      end
      if (clipped_o) n_clip++;
      model_next();
      @(posedge clk);
      #1;
      cyc++;
      chk("pix_valid", 32'(pix_valid_o), 32'(m_ov));
      chk("pix_x", 32'(pix_x_o), 32'(m_x));
      chk("pix_y", 32'(pix_y_o), 32'(m_y));
      chk("pix_rgb", 32'({pix_r_o, pix_g_o, pix_b_o}), 32'({m_r, m_g, m_b}));
      chk("flush_done", 32'(flush_done_o), 32'(m_done));
      chk("busy", 32'(busy_o), 32'(m_owner >= 0 || m_flushing || m_ov));
      chk("pix_count", 32'(pix_count_o), 32'(m_cnt));
      if (pix_valid_o) begin
         n_out++;
         if (first_out < 0) first_out = cyc;
         last_out = cyc;
      end
      if (flush_done_o) begin
         done_seen = 1;
         done_cyc  = cyc;
      end
   endtask

   function automatic bit work_left();
      bit w;
      w = (m_owner >= 0) || m_flushing || m_ov;
      for (int i = 0; i < N; i++) w |= hold[i] || (left[i] > 0) || (quota[i] > 0);
      return w;
   endfunction

   task automatic drain(input string tag);
      int k;
      k = 0;
      rpct = 100;
      while (work_left() && k < 400) begin
         step();
         k++;
      end
      chk({tag, "_drain"}, 32'(k < 400), 32'd1);
   endtask

   task automatic do_reset();
      rst_req = 1;
      step();
   endtask

   task automatic clear_obs();
      cyc = 0; first_out = -1; last_out = -1; n_out = 0; n_clip = 0;
      done_seen = 0; done_cyc = -1; circ_cyc = -1; prev_last = 1;
      order_q.delete();
   endtask

   int exp_ord[5] = '{0, 1, 2, 3, 0};

   initial begin
      int k;
      model_reset();
      rst = 1;
      @(posedge clk);
      #1;
      chk("rst_pix_valid", 32'(pix_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_count", 32'(pix_count_o), 32'd0);
      chk("rst_ready", 32'(req_ready_o), 32'd0);
      chk("rst_flush_done", 32'(flush_done_o), 32'd0);
      chk("rst_pix_x", 32'(pix_x_o), 32'd0);

      // Line draws a 3-pixel primitive at full throughput
      clear_obs();
      len_fix = 3; quota[0] = 1;
      drain("t1");
      chk("t1_first_out", 32'(first_out), 32'd2);
      chk("t1_last_out", 32'(last_out), 32'd4);
      chk("t1_n_out", 32'(n_out), 32'd3);
      chk("t1_count", 32'(pix_count_o), 32'd3);
      chk("t1_idle", 32'(busy_o), 32'd0);

      // All four requesters with 2-pixel primitives, line twice
      do_reset();
      clear_obs();
      len_fix = 2; quota[0] = 2; quota[1] = 1; quota[2] = 1; quota[3] = 1;
      drain("t2");
      chk("t2_nprims", 32'(order_q.size()), 32'd5);
      for (int j = 0; j < 5; j++)
         chk("t2_order", (j < order_q.size()) ? 32'(order_q[j]) : 32'hffff_ffff, 32'(exp_ord[j]));
      chk("t2_count", 32'(pix_count_o), 32'd10);

      // Back-pressure for 5 cycles in the middle of a primitive
      do_reset();
      clear_obs();
      len_fix = 6; quota[0] = 1;
      for (int j = 0; j < 3; j++) step();
      rpct = 0;
      for (int j = 0; j < 5; j++) step();
      drain("t3");
      chk("t3_count", 32'(pix_count_o), 32'd6);

      // Flush during fill's 4-pixel primitive while circle waits
      do_reset();
      clear_obs();
      len_fix = 4; quota[1] = 1; quota[2] = 1;
      k = 0;
      while (m_owner != 1 && k < 20) begin
         step();
         k++;
      end
      chk("t4_fill_granted", 32'(m_owner == 1), 32'd1);
      step();
      flush_req = 1;
      step();
      drain("t4");
      chk("t4_done_seen", 32'(done_seen), 32'd1);
      chk("t4_circle_after_done", 32'(circ_cyc > done_cyc), 32'd1);
      chk("t4_count", 32'(pix_count_o), 32'd4);

      // Out-of-frame pixel carrying last
      do_reset();
      clear_obs();
      hold[3] = 1; gl[3] = 1; left[3] = 1;
      gx[3] = XW'(`WIDTH); gy[3] = YW'(5); gr[3] = 8'h12; gg[3] = 8'h34; gb[3] = 8'h56;
      drain("t5");
      chk("t5_clipped", 32'(n_clip), CLIP ? 32'd1 : 32'd0);
      chk("t5_outputs", 32'(n_out), CLIP ? 32'd0 : 32'd1);
      chk("t5_idle", 32'(busy_o), 32'd0);

      // Reset while a pixel is held in LOCKED
      do_reset();
      len_fix = 0; vpct = 80; rpct = 30;
      for (int i = 0; i < N; i++) quota[i] = 1000;
      k = 0;
      while (!(m_owner >= 0 && m_ov) && k < 50) begin
         step();
         k++;
      end
      chk("t6_reached_locked", 32'(m_owner >= 0 && m_ov), 32'd1);
      rst_req = 1;
      step();
      chk("t6_pix_valid", 32'(pix_valid_o), 32'd0);
      chk("t6_busy", 32'(busy_o), 32'd0);
      chk("t6_count", 32'(pix_count_o), 32'd0);
      chk("t6_pix_data", 32'({pix_x_o, pix_y_o}), 32'd0);

      // Free-running random traffic with flushes and occasional resets
      vpct = 70; rpct = 60; clip_pct = 10;
      for (int j = 0; j < 3000; j++) begin
         if ($urandom_range(0, 99) < 3) flush_req = 1;
         if ($urandom_range(0, 499) == 0) rst_req = 1;
         step();
      end
      for (int i = 0; i < N; i++) quota[i] = 0;
      drain("rand");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
